// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mips_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } mc_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_mc_next_state.sv
// Combinational next-state function of the multicycle control FSM.
module mips_mc_next_state
    import mips_multicycle_ctrl_pkg::*;
(
    input  mc_state_t   state,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output mc_state_t   next_state
);

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            // Only lw/sw reach here, so anything other than sw is treated as lw.
            MEMADR:  next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   next_state = mem_ready ? MEMWB : MEMRD;
            MEMWB:   next_state = FETCH;
            MEMWR:   next_state = mem_ready ? FETCH : MEMWR;
            EXECUTE: next_state = ALUWB;
            ALUWB:   next_state = FETCH;
            BRANCH:  next_state = FETCH;
            ADDIEX:  next_state = ADDIWB;
            ADDIWB:  next_state = FETCH;
            JUMP:    next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with a request/ready memory handshake.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        branch,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        instr_done,
    output logic        illegal_op,
    output logic [3:0]  state
);

    mc_state_t state_q, state_d;
    logic      ready;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state = state_q;

    mips_mc_next_state u_next_state (
        .state      (state_q),
        .opcode     (opcode),
        .mem_ready  (ready),
        .next_state (state_d)
    );

    // Reset wins over any pending access; memory must tolerate the abandoned request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = ready;
                pc_write  = ready;
            end
            DECODE: begin
                alu_src_b  = SRCB_IMM_SH2;
                illegal_op = !op_is_legal(opcode);
                instr_done = !op_is_legal(opcode);
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = ready;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                branch     = 1'b1;
                pc_src     = PCSRC_ALUOUT;
                instr_done = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed scenarios plus random instruction streams.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        mem_req, mem_write, iord, ir_write, pc_write, branch;
    logic [1:0]  pc_src, alu_src_b, alu_op;
    logic        alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
    logic [3:0]  state;
    logic [17:0] obs;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_R = 6'b000000;
    localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    assign obs = {mem_req, mem_write, iord, ir_write, pc_write, branch, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op};

    function automatic bit legal(input logic [5:0] op);
        return op == T_LW || op == T_SW || op == T_R || op == T_BEQ || op == T_ADDI || op == T_J;
    endfunction

    function automatic int cpi(input logic [5:0] op);
        case (op)
            T_LW:               return 5;
            T_SW, T_R, T_ADDI:  return 4;
            T_BEQ, T_J:         return 3;
            default:            return 2;
        endcase
    endfunction

    // Expected control word for one cycle, straight from the per-step control table.
    function automatic logic [17:0] exp_vec(input int s, input bit rdy, input bit lgl);
        bit mreq = 0, mw = 0, io = 0, irw = 0, pcw = 0, br = 0, asa = 0;
        bit rd = 0, m2r = 0, rw = 0, done = 0, ill = 0;
        bit [1:0] pcs = 0, asb = 0, aop = 0;
        case (s)
            0:  begin mreq = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
            1:  begin asb = 2'd3; ill = !lgl; done = !lgl; end
            2:  begin asa = 1; asb = 2'd2; end
            3:  begin mreq = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mreq = 1; mw = 1; io = 1; done = rdy; end
            6:  begin asa = 1; aop = 2'd2; end
            7:  begin rw = 1; rd = 1; done = 1; end
            8:  begin asa = 1; aop = 2'd1; br = 1; pcs = 2'd1; done = 1; end
            9:  begin asa = 1; asb = 2'd2; end
            10: begin rw = 1; done = 1; end
            11: begin pcw = 1; pcs = 2'd2; done = 1; end
            default: ;
        endcase
        return {mreq, mw, io, irw, pcw, br, pcs, asa, asb, aop, rd, m2r, rw, done, ill};
    endfunction

    task automatic cyc(input int s, input bit rdy, input logic [5:0] op, input bit lgl,
                       output bit done);
        logic [17:0] e;
        mem_ready = rdy;
        opcode = op;
        #1;
        e = exp_vec(s, rdy, lgl);
        checks++;
        assert (state === 4'(s)) else begin
            errors++;
            $error("FAIL state: observed %0d expected %0d", state, s);
        end
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL ctrl(state %0d rdy %0d): observed %b expected %b", s, rdy, obs, e);
        end
        done = instr_done;
        @(posedge clk);
        #1;
    endtask

    // One instruction; wf/wm are wait cycles before ready in fetch / data access (-1 = random).
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        int path[$];
        int waits = 0, n = 0, first_done = 0, n_done = 0;
        bit lgl = legal(op);
        bit d;
        path = '{0, 1};
        case (op)
            T_LW:   path = '{0, 1, 2, 3, 4};
            T_SW:   path = '{0, 1, 2, 5};
            T_R:    path = '{0, 1, 6, 7};
            T_BEQ:  path = '{0, 1, 8};
            T_ADDI: path = '{0, 1, 9, 10};
            T_J:    path = '{0, 1, 11};
            default: ;
        endcase
        foreach (path[i]) begin
            int s = path[i];
            if (s == 0 || s == 3 || s == 5) begin
                int w = (s == 0) ? wf : wm;
                if (w < 0) w = $urandom_range(0, 3);
                for (int k = 0; k < w; k++) begin
                    cyc(s, 1'b0, (s == 0) ? 6'($urandom) : op, lgl, d);
                    n++; waits++;
                    if (d) begin n_done++; if (first_done == 0) first_done = n; end
                end
                cyc(s, 1'b1, (s == 0) ? 6'($urandom) : op, lgl, d);
            end else begin
                cyc(s, 1'($urandom_range(0, 1)), op, lgl, d);
            end
            n++;
            if (d) begin n_done++; if (first_done == 0) first_done = n; end
        end
        checks++;
        assert (first_done === cpi(op) + waits) else begin
            errors++;
            $error("FAIL latency op %b: observed %0d expected %0d", op, first_done,
                   cpi(op) + waits);
        end
        checks++;
        assert (n_done === 1) else begin
            errors++;
            $error("FAIL done_pulses op %b: observed %0d expected 1", op, n_done);
        end
    endtask

    initial begin
        bit d;
        logic [5:0] op;
        rst = 1'b1;
        mem_ready = 1'b0;
        opcode = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(T_LW, 0, 0);
        run_instr(T_SW, 0, 3);
        run_instr(T_R, 0, 0);
        run_instr(T_BEQ, 0, 0);
        run_instr(T_J, 0, 0);
        run_instr(T_ADDI, 2, 0);
        run_instr(6'b111111, 0, 0);

        // Reset while a data read is stalled: the load never writes back.
        cyc(0, 1'b1, 6'd0, 1'b1, d);
        cyc(1, 1'b0, T_LW, 1'b1, d);
        cyc(2, 1'b0, T_LW, 1'b1, d);
        cyc(3, 1'b0, T_LW, 1'b1, d);
        mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr(T_ADDI, 1, 0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 6))
                0: op = T_LW;
                1: op = T_SW;
                2: op = T_R;
                3: op = T_BEQ;
                4: op = T_ADDI;
                5: op = T_J;
                default: begin
                    do op = 6'($urandom); while (legal(op));
                end
            endcase
            run_instr(op, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
